// File: rtl/booth_mult_seq.sv
// Purpose : sequential radix-4 Booth multiplier, signed or unsigned, WIDTH x WIDTH -> 2*WIDTH.
// Latency : done pulses N+1 cycles after start is sampled (N = WIDTH/2 signed, WIDTH/2+1 unsigned).
// Backpres: start is accepted only while busy=0 (IDLE or DONE); starts during RUN are ignored.
//
// Optional feature macro: BOOTH_EARLY_EXIT_EN -- when defined, RUN ends as soon as the remaining
// multiplier bits (overlap bit included) can only produce zero Booth digits. Results are unchanged.
//
// Ports:
//   clock        - single clock, rising-edge state updates
//   reset_n      - asynchronous active-low reset
//   start        - begin a multiply (sampled only when busy=0)
//   is_signed    - 1: two's-complement operands, 0: unsigned operands
//   multiplicand - M operand
//   multiplier   - Q operand
//   busy         - high while an operation is in RUN
//   done         - one-cycle pulse when prod_hi/prod_lo carry a new result
//   prod_hi      - upper WIDTH bits of the product (held until the next done)
//   prod_lo      - lower WIDTH bits of the product (held until the next done)
module booth_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  // Partial products live in 2*WIDTH+2 bits so that +/-2M of a sign- or
  // zero-extended operand never overflows before truncation to 2*WIDTH.
  localparam int P  = 2*WIDTH + 2;
  // Multiplier shift register: two extension bits on top (room for the extra
  // unsigned digit) and the q[-1]=0 overlap bit at the bottom.
  localparam int QW = WIDTH + 3;
  localparam int CW = $clog2(WIDTH/2 + 2);
  localparam logic [CW-1:0] LAST_S = CW'(WIDTH/2 - 1);
  localparam logic [CW-1:0] LAST_U = CW'(WIDTH/2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [P-1:0]   m_sh;     // multiplicand pre-scaled by 4^digit_index
  logic [P-1:0]   acc;      // running sum of partial products
  logic [QW-1:0]  q_sh;     // multiplier, current triplet in [2:0]
  logic           sgn;      // latched is_signed
  logic           fin;      // last digit has been retired
  logic [CW-1:0]  cnt;      // digits retired so far

  logic [P-1:0]   pp;
  logic [P-1:0]   m_ext;
  logic [QW-1:0]  q_ext;
  logic [QW-1:0]  q_next;
  logic           fill;
  logic           last_digit;
  logic           unused_acc_top;

  // Bits above 2*WIDTH only absorb the carries of the wide arithmetic.
  assign unused_acc_top = ^acc[P-1:2*WIDTH];

  always_comb begin
    m_ext = is_signed ? {{(P-WIDTH){multiplicand[WIDTH-1]}}, multiplicand}
                      : {{(P-WIDTH){1'b0}}, multiplicand};
    q_ext = {{2{is_signed & multiplier[WIDTH-1]}}, multiplier, 1'b0};

    // Shift in copies of the sign (signed) or zeros (unsigned) so that digits
    // beyond the operand width decode correctly.
    fill   = sgn & q_sh[QW-1];
    q_next = {fill, fill, q_sh[QW-1:2]};

    pp = '0;
    case (q_sh[2:0])
      3'b001, 3'b010: pp = m_sh;
      3'b011:         pp = m_sh << 1;
      3'b100:         pp = -(m_sh << 1);
      3'b101, 3'b110: pp = -m_sh;
      default:        pp = '0;
    endcase

    last_digit = (cnt == (sgn ? LAST_S : LAST_U));
`ifdef BOOTH_EARLY_EXIT_EN
    // Remaining bits all equal (signed) or all zero (unsigned) decode only to
    // zero digits, so the accumulator is already final.
    if (sgn) begin
      last_digit = last_digit | (&q_next) | ~(|q_next);
    end else begin
      last_digit = last_digit | ~(|q_next);
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      prod_hi <= '0;
      prod_lo <= '0;
      m_sh    <= '0;
      acc     <= '0;
      q_sh    <= '0;
      sgn     <= 1'b0;
      fin     <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            m_sh  <= m_ext;
            q_sh  <= q_ext;
            sgn   <= is_signed;
            acc   <= '0;
            cnt   <= '0;
            fin   <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (fin) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            prod_hi <= acc[2*WIDTH-1:WIDTH];
            prod_lo <= acc[WIDTH-1:0];
          end else begin
            acc  <= acc + pp;
            m_sh <= m_sh << 2;
            q_sh <= q_next;
            cnt  <= cnt + 1'b1;
            fin  <= last_digit;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
